cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-port arbiter between the instruction cache and data cache downward-facing ports and the single shared 256-bit line memory port. It grants the memory to exactly one cache per transaction using round-robin fairness, holds the request stable until the memory responds, and routes the response back to the owner. It also exports per-cache ownership flags (`i_in_arbit`, `d_in_arbit`). A cache uses its flag to decide whether to wait out an in-flight allocate after a branch.

## Interface
- No parameters. Line width is fixed at 256 bits and address width at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_addr` in 32, `i_read` in 1: icache line read request. Icache never writes.
- `i_rdata` out 256, `i_resp` out 1, `i_in_arbit` out 1: icache response, and icache-owns-memory flag.
- `d_addr` in 32, `d_read` in 1, `d_write` in 1, `d_wdata` in 256: dcache line request.
- `d_rdata` out 256, `d_resp` out 1, `d_in_arbit` out 1: dcache response, and dcache-owns-memory flag.
- `mem_addr` out 32, `mem_read` out 1, `mem_write` out 1, `mem_wdata` out 256: memory request.
- `mem_rdata` in 256, `mem_resp` in 1: memory response.

## Operation
- States: `s_idle`, `s_i_busy`, `s_d_busy`. Register `last_grant` holds 0 for I and 1 for D. It resets to 1, so I wins the first tie.
- **`s_idle`:**
  - A requester is pending if it has `*_read` or `*_write` high.
  - If only one is pending, grant it.
  - If both are pending, grant the one that is not `last_grant`.
  - On grant, latch the address with bits [4:0] forced to 0, the command, and `d_wdata`. Update `last_grant` and move to the owner's busy state.
- **Command conflict:** if `d_read` and `d_write` are both high, latch a write.
- **`s_*_busy`:**
  - Drive the latched `mem_addr`, `mem_read` or `mem_write`, and `mem_wdata` from registers. They are held constant until `mem_resp`.
  - Requester inputs are ignored in this state. The transaction completes even if the owner drops its request or a branch occurs.
  - On `mem_resp`: pulse the owner's `*_resp` for that one cycle, clear `mem_read`/`mem_write`, and return to `s_idle`.
- **Data routing:**
  - `i_rdata` and `d_rdata` equal `mem_rdata` combinationally. Each is valid only while its `*_resp` is high.
  - `*_resp` = `mem_resp` AND owner match. It is never asserted for the non-owner.
- **Ownership flags:** `i_in_arbit` is high exactly while in `s_i_busy`; `d_in_arbit` likewise for `s_d_busy`. Both flags are never high together.
- **Stray response:** a `mem_resp` arriving in `s_idle` is ignored. No `*_resp` is asserted and the state does not change.
- **Reset:**
  - All state, outputs and `last_grant` clear immediately on `rst_n` falling, even mid-transaction: `mem_read`, `mem_write`, `*_resp` and `*_in_arbit` go to 0, and state goes to `s_idle`.
  - `mem_addr` and `mem_wdata` reset to 0.

## Timing
- The request is sampled in `s_idle` at edge t.
- `mem_read`/`mem_write` and `*_in_arbit` are high from t+1.
- `mem_resp` at cycle r gives `*_resp` in the same cycle r. Outputs are deasserted and the state is `s_idle` from r+1.
- A pending request seen at edge r+1 issues at r+2. The minimum spacing between memory commands is therefore one idle cycle.
- The earliest possible `mem_resp` is the cycle after the command is first driven. A response coincident with command assertion is not possible.
- A dcache write-back followed by an allocate takes two grants. A pending icache request wins the second grant (round-robin), so the dcache allocate waits one transaction.

## Test plan
- Single icache read:
  - Stimulus: `i_read`=1, `i_addr`=0x0000_1234; memory responds 3 cycles after `mem_read`.
  - Required: `mem_addr`=0x0000_1220; `i_resp` for 1 cycle with `i_rdata`=`mem_rdata`; `d_resp` stays 0; `i_in_arbit` is high 4 cycles.
- Simultaneous requests from reset:
  - Stimulus: `i_read` and `d_read` held high together.
  - Required: grants alternate I, D, I, D for 4 transactions; each `*_resp` goes only to its owner.
- Dcache write:
  - Stimulus: `d_write`=1, `d_wdata`=pattern A; `d_addr` and `d_wdata` are changed mid-transaction.
  - Required: `mem_write` is high with the original address and pattern A held until `mem_resp`.
- Owner drops its request:
  - Stimulus: the icache drops `i_read` mid-transaction (branch).
  - Required: `mem_read` stays high, `i_resp` still pulses on `mem_resp`, and `i_in_arbit` falls the cycle after.
- Stray response:
  - Stimulus: `mem_resp`=1 while in `s_idle`.
  - Required: no `*_resp`; state and `last_grant` unchanged.
- Asynchronous reset mid-transaction:
  - Stimulus: `rst_n` pulsed low between clock edges during `s_d_busy`.
  - Required: `mem_write`, `d_in_arbit` and `d_resp` drop to 0 before the next edge. The next simultaneous request after reset grants I first.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side bus bundle for the shared line-memory arbiter.
// The slave view belongs to the arbiter; the master view to the caches and memory around it.
interface cache_mem_arbiter_if;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         i_in_arbit;

    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         d_in_arbit;

    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, i_in_arbit, d_rdata, d_resp, d_in_arbit,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, i_in_arbit, d_rdata, d_resp, d_in_arbit,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter granting the shared 256-bit line memory to the icache or dcache,
// one whole transaction at a time, with the memory request held in registers until mem_resp.
module cache_mem_arbiter (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_I_BUSY = 2'd1,
        S_D_BUSY = 2'd2
    } state_t;

    state_t       r_state, w_state_next;
    logic         r_last_grant, w_last_grant_next;   // 0 = icache, 1 = dcache
    logic [31:0]  r_mem_addr, w_mem_addr_next;
    logic         r_mem_read, w_mem_read_next;
    logic         r_mem_write, w_mem_write_next;
    logic [255:0] r_mem_wdata, w_mem_wdata_next;

    logic w_i_pend, w_d_pend, w_grant_i, w_grant_d;

    assign w_i_pend  = bus.i_read;
    assign w_d_pend  = bus.d_read | bus.d_write;
    // On a tie the requester that did not win last time takes the grant.
    assign w_grant_i = w_i_pend & (~w_d_pend | r_last_grant);
    assign w_grant_d = w_d_pend & (~w_i_pend | ~r_last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_read   <= w_mem_read_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_wdata  <= w_mem_wdata_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_mem_addr_next   = r_mem_addr;
        w_mem_read_next   = r_mem_read;
        w_mem_write_next  = r_mem_write;
        w_mem_wdata_next  = r_mem_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_grant_i) begin
                    w_state_next      = S_I_BUSY;
                    w_last_grant_next = 1'b0;
                    w_mem_addr_next   = {bus.i_addr[31:5], 5'b0};
                    w_mem_read_next   = 1'b1;
                    w_mem_write_next  = 1'b0;
                    w_mem_wdata_next  = bus.d_wdata;
                end else if (w_grant_d) begin
                    // A simultaneous read and write from the dcache is taken as a write.
                    w_state_next      = S_D_BUSY;
                    w_last_grant_next = 1'b1;
                    w_mem_addr_next   = {bus.d_addr[31:5], 5'b0};
                    w_mem_read_next   = ~bus.d_write;
                    w_mem_write_next  = bus.d_write;
                    w_mem_wdata_next  = bus.d_wdata;
                end
            end
            S_I_BUSY, S_D_BUSY: begin
                if (bus.mem_resp) begin
                    w_state_next     = S_IDLE;
                    w_mem_read_next  = 1'b0;
                    w_mem_write_next = 1'b0;
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_mem_read_next  = 1'b0;
                w_mem_write_next = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_wdata  = r_mem_wdata;

    assign bus.i_rdata    = bus.mem_rdata;
    assign bus.d_rdata    = bus.mem_rdata;
    assign bus.i_in_arbit = (r_state == S_I_BUSY);
    assign bus.d_in_arbit = (r_state == S_D_BUSY);
    assign bus.i_resp     = bus.mem_resp & (r_state == S_I_BUSY);
    assign bus.d_resp     = bus.mem_resp & (r_state == S_D_BUSY);
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized transaction bench for cache_mem_arbiter with a transaction-level
// round-robin reference model.
module tb_cache_mem_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    bit   exp_last_d;   // model: last grant went to the dcache

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.i_read    = 1'b0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.mem_resp  = 1'b0;
    endtask

    // One whole transaction: present the requests, check the grant against the model,
    // hold for 'delay' cycles, answer, and check routing and return to idle.
    task automatic run_txn(input logic ir, input logic [31:0] ia, input logic dr,
                           input logic dw, input logic [31:0] da, input logic [255:0] dwd,
                           input int delay, input bit disturb);
        bit           own_d;
        logic [31:0]  exp_addr;
        bit           exp_wr;
        logic [255:0] rdata;

        if (ir && (dr || dw)) own_d = !exp_last_d;
        else                  own_d = !ir;
        exp_last_d = own_d;
        exp_addr   = (own_d ? da : ia) & 32'hFFFF_FFE0;
        exp_wr     = own_d && dw;

        bus.i_read  = ir;
        bus.i_addr  = ia;
        bus.d_read  = dr;
        bus.d_write = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        tick();

        $display("txn owner=%s addr=%h write=%0d delay=%0d disturb=%0d",
                 own_d ? "D" : "I", exp_addr, exp_wr, delay, disturb);
        check_bit("grant_i_in_arbit", bus.i_in_arbit, !own_d);
        check_bit("grant_d_in_arbit", bus.d_in_arbit, own_d);
        check_vec("grant_mem_addr", 256'(bus.mem_addr), 256'(exp_addr));
        check_bit("grant_mem_read", bus.mem_read, !exp_wr);
        check_bit("grant_mem_write", bus.mem_write, exp_wr);
        if (exp_wr) check_vec("grant_mem_wdata", bus.mem_wdata, dwd);

        for (int k = 0; k < delay; k++) begin
            if (disturb && k == 0) begin
                bus.i_read  = 1'b0;
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
                bus.i_addr  = $urandom;
                bus.d_addr  = $urandom;
                bus.d_wdata = rand256();
            end
            tick();
            check_vec("hold_mem_addr", 256'(bus.mem_addr), 256'(exp_addr));
            check_bit("hold_mem_read", bus.mem_read, !exp_wr);
            check_bit("hold_mem_write", bus.mem_write, exp_wr);
            if (exp_wr) check_vec("hold_mem_wdata", bus.mem_wdata, dwd);
            check_bit("hold_i_in_arbit", bus.i_in_arbit, !own_d);
            check_bit("hold_d_in_arbit", bus.d_in_arbit, own_d);
            check_bit("hold_no_resp", bus.i_resp | bus.d_resp, 1'b0);
        end

        rdata         = rand256();
        bus.mem_rdata = rdata;
        bus.mem_resp  = 1'b1;
        #1;
        check_bit("resp_i", bus.i_resp, !own_d);
        check_bit("resp_d", bus.d_resp, own_d);
        if (own_d) check_vec("resp_d_rdata", bus.d_rdata, rdata);
        else       check_vec("resp_i_rdata", bus.i_rdata, rdata);

        tick();
        bus.mem_resp = 1'b0;
        check_bit("done_mem_read", bus.mem_read, 1'b0);
        check_bit("done_mem_write", bus.mem_write, 1'b0);
        check_bit("done_i_in_arbit", bus.i_in_arbit, 1'b0);
        check_bit("done_d_in_arbit", bus.d_in_arbit, 1'b0);
    endtask

    initial begin
        logic        r_ir, r_dr, r_dw;
        n_checks   = 0;
        n_pass     = 0;
        exp_last_d = 1'b1;
        rst_n      = 1'b0;
        bus.i_addr    = '0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        clear_inputs();
        #1;
        check_bit("reset_mem_read", bus.mem_read, 1'b0);
        check_bit("reset_mem_write", bus.mem_write, 1'b0);
        check_vec("reset_mem_addr", 256'(bus.mem_addr), 256'd0);
        check_vec("reset_mem_wdata", bus.mem_wdata, 256'd0);
        check_bit("reset_in_arbit", bus.i_in_arbit | bus.d_in_arbit, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous reads from reset: grants alternate starting with the icache.
        for (int n = 0; n < 4; n++)
            run_txn(1'b1, $urandom, 1'b1, 1'b0, $urandom, rand256(), 1 + n, 1'b0);

        // Single icache read answered three cycles after mem_read.
        run_txn(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, '0, 3, 1'b0);

        // Dcache write with address and data changed mid-transaction.
        run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'hABCD_0047, {8{32'hA5A5_5A5A}}, 3, 1'b1);

        // Icache drops its request mid-transaction.
        run_txn(1'b1, 32'h0000_8F3C, 1'b0, 1'b0, 32'h0, '0, 2, 1'b1);

        // Stray response while idle.
        clear_inputs();
        bus.mem_resp = 1'b1;
        #1;
        check_bit("stray_i_resp", bus.i_resp, 1'b0);
        check_bit("stray_d_resp", bus.d_resp, 1'b0);
        tick();
        bus.mem_resp = 1'b0;
        check_bit("stray_in_arbit", bus.i_in_arbit | bus.d_in_arbit, 1'b0);
        check_bit("stray_mem_read", bus.mem_read, 1'b0);
        run_txn(1'b1, $urandom, 1'b1, 1'b0, $urandom, rand256(), 1, 1'b0);

        // Randomized transactions, including read/write conflicts on the dcache.
        for (int n = 0; n < 40; n++) begin
            r_ir = 1'($urandom_range(0, 1));
            r_dr = 1'($urandom_range(0, 1));
            r_dw = 1'($urandom_range(0, 1));
            if (!r_ir && !r_dr && !r_dw) r_ir = 1'b1;
            run_txn(r_ir, $urandom, r_dr, r_dw, $urandom, rand256(),
                    $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a dcache write.
        clear_inputs();
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_4444;
        bus.d_wdata = rand256();
        tick();
        check_bit("pre_reset_d_in_arbit", bus.d_in_arbit, 1'b1);
        check_bit("pre_reset_mem_write", bus.mem_write, 1'b1);
        #2;
        rst_n        = 1'b0;
        bus.mem_resp = 1'b1;
        #1;
        check_bit("async_mem_write", bus.mem_write, 1'b0);
        check_bit("async_d_in_arbit", bus.d_in_arbit, 1'b0);
        check_bit("async_d_resp", bus.d_resp, 1'b0);
        check_vec("async_mem_addr", 256'(bus.mem_addr), 256'd0);
        clear_inputs();
        #1;
        rst_n      = 1'b1;
        exp_last_d = 1'b1;
        tick();
        run_txn(1'b1, $urandom, 1'b1, 1'b0, $urandom, rand256(), 2, 1'b0);
        run_txn(1'b1, $urandom, 1'b1, 1'b0, $urandom, rand256(), 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
